// File: rtl/qar_timer_array.sv
// Multi-channel timer for qar_core: per-channel compare/PWM/capture plus a
// shared two-stage watchdog, on a zero-wait-state valid/we peripheral bus.
module qar_timer_array #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned PRESC_WIDTH = 8,
    parameter int unsigned WDT_WIDTH   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_valid,
    input  logic              bus_we,
    input  logic [7:0]        bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic              bus_ready,
    output logic [31:0]       bus_rdata,
    input  logic [NUM_CH-1:0] cap_in,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq_timer,
    output logic              wdt_rst_req
);

    localparam logic [31:0] KICK_KEY = 32'h0000_5A5A;
    localparam logic [5:0]  A_CTRL   = 6'h00;
    localparam logic [5:0]  A_STATUS = 6'h01;
    localparam logic [5:0]  A_WLOAD  = 6'h02;
    localparam logic [5:0]  A_WKICK  = 6'h03;

    logic                   ctrl_en_q, ctrl_en_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d, presc_cnt_q, presc_cnt_d;
    logic                   tick_c;

    logic [CNT_WIDTH-1:0] cmp_q  [NUM_CH];
    logic [CNT_WIDTH-1:0] cmp_d  [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_q [NUM_CH];
    logic [CNT_WIDTH-1:0] duty_d [NUM_CH];
    logic [CNT_WIDTH-1:0] cap_q  [NUM_CH];
    logic [CNT_WIDTH-1:0] cap_d  [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_q  [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_d  [NUM_CH];

    logic [NUM_CH-1:0] run_q, run_d, pwm_en_q, pwm_en_d, cap_en_q, cap_en_d;
    logic [NUM_CH-1:0] cap_edge_q, cap_edge_d, one_shot_q, one_shot_d, irq_en_q, irq_en_d;
    logic [NUM_CH-1:0] match_q, match_d, capf_q, capf_d, ovr_q, ovr_d;
    logic [NUM_CH-1:0] match_set, cap_set, ovr_set;
    logic [NUM_CH-1:0] sync1_q, sync2_q, sync3_q, cap_ev_c, pwm_d;
    logic              bark_q, bark_d, bark_set, rst_set, irq_d, wdt_rst_req_d;

    logic [WDT_WIDTH-1:0] wdt_load_q, wdt_load_d, wdt_cnt_q, wdt_cnt_d;
    logic                 wdt_en_q, wdt_en_d;

    logic              wr_c, rd_c, kick_c;
    logic [5:0]        word_c;
    logic [1:0]        sub_c;
    logic [NUM_CH-1:0] ch_hit_c;
    logic [31:0]       status_c, clr_c;
    logic              unused_addr_bits;

    assign bus_ready        = bus_valid;
    assign wr_c             = bus_valid & bus_we;
    assign rd_c             = bus_valid & ~bus_we;
    assign word_c           = bus_addr[7:2];
    assign sub_c            = bus_addr[3:2];
    assign unused_addr_bits = ^bus_addr[1:0];
    assign kick_c           = wr_c && (word_c == A_WKICK) && (bus_wdata == KICK_KEY);
    assign tick_c           = ctrl_en_q && (presc_cnt_q >= presc_q);
    assign clr_c            = (wr_c && word_c == A_STATUS) ? bus_wdata : 32'h0;
    assign cap_ev_c         = cap_en_q & ((~cap_edge_q & sync2_q & ~sync3_q) |
                                          ( cap_edge_q & ~sync2_q & sync3_q));

    // Channel n occupies 0x10 bytes starting at 0x10 + 0x10*n
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) ch_hit_c[i] = (bus_addr[7:4] == 4'(i + 1));
    end

    always_comb begin
        status_c              = '0;
        status_c[NUM_CH-1:0]  = match_q;
        status_c[8 +: NUM_CH] = capf_q;
        status_c[16 +: NUM_CH] = ovr_q;
        status_c[31]          = bark_q;
    end

    // Read mux; the kick address reads back the live watchdog count
    always_comb begin
        bus_rdata = '0;
        if (rd_c) begin
            case (word_c)
                A_CTRL: begin
                    bus_rdata[0]                = ctrl_en_q;
                    bus_rdata[8 +: PRESC_WIDTH] = presc_q;
                end
                A_STATUS: bus_rdata = status_c;
                A_WLOAD:  bus_rdata = 32'(wdt_load_q);
                A_WKICK:  bus_rdata = 32'(wdt_cnt_q);
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (ch_hit_c[i]) begin
                            case (sub_c)
                                2'd0: bus_rdata = 32'(cmp_q[i]);
                                2'd1: bus_rdata = 32'(duty_q[i]);
                                2'd2: bus_rdata = 32'(cap_q[i]);
                                2'd3: bus_rdata = 32'({irq_en_q[i], one_shot_q[i], cap_edge_q[i],
                                                       cap_en_q[i], pwm_en_q[i], run_q[i]});
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        ctrl_en_d     = ctrl_en_q;
        presc_d       = presc_q;
        presc_cnt_d   = (!ctrl_en_q || tick_c) ? '0 : presc_cnt_q + PRESC_WIDTH'(1);
        run_d         = run_q;
        pwm_en_d      = pwm_en_q;
        cap_en_d      = cap_en_q;
        cap_edge_d    = cap_edge_q;
        one_shot_d    = one_shot_q;
        irq_en_d      = irq_en_q;
        match_set     = '0;
        cap_set       = '0;
        ovr_set       = '0;
        bark_set      = 1'b0;
        rst_set       = 1'b0;
        wdt_load_d    = wdt_load_q;
        wdt_cnt_d     = wdt_cnt_q;
        wdt_en_d      = wdt_en_q;
        pwm_d         = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cmp_d[i]  = cmp_q[i];
            duty_d[i] = duty_q[i];
            cap_d[i]  = cap_q[i];
            cnt_d[i]  = cnt_q[i];
        end

        if (wr_c && word_c == A_CTRL) begin
            ctrl_en_d = bus_wdata[0];
            presc_d   = bus_wdata[8 +: PRESC_WIDTH];
        end

        // Hardware count first so a same-cycle bus write overrides it
        for (int i = 0; i < NUM_CH; i++) begin
            if (tick_c && run_q[i]) begin
                if (cnt_q[i] == cmp_q[i]) begin
                    match_set[i] = 1'b1;
                    cnt_d[i]     = '0;
                    if (one_shot_q[i]) run_d[i] = 1'b0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
                end
            end
            if (wr_c && ch_hit_c[i]) begin
                case (sub_c)
                    2'd0: begin
                        cmp_d[i] = bus_wdata[CNT_WIDTH-1:0];
                        cnt_d[i] = '0;
                    end
                    2'd1: duty_d[i] = bus_wdata[CNT_WIDTH-1:0];
                    2'd3: begin
                        run_d[i]      = bus_wdata[0];
                        pwm_en_d[i]   = bus_wdata[1];
                        cap_en_d[i]   = bus_wdata[2];
                        cap_edge_d[i] = bus_wdata[3];
                        one_shot_d[i] = bus_wdata[4];
                        irq_en_d[i]   = bus_wdata[5];
                        cnt_d[i]      = '0;
                    end
                    default: ;
                endcase
            end
            if (cap_ev_c[i]) begin
                cap_d[i]   = cnt_d[i];
                cap_set[i] = 1'b1;
                ovr_set[i] = capf_q[i];
            end
            pwm_d[i] = pwm_en_q[i] & run_q[i] & (cnt_q[i] < duty_q[i]);
        end

        // Expiry is the decrement that would land on zero; a kick overrides it
        if (wdt_en_q) begin
            if (kick_c) begin
                wdt_cnt_d = wdt_load_q;
            end else if (wdt_cnt_q <= WDT_WIDTH'(1)) begin
                wdt_cnt_d = wdt_load_q;
                if (bark_q) rst_set  = 1'b1;
                else        bark_set = 1'b1;
            end else begin
                wdt_cnt_d = wdt_cnt_q - WDT_WIDTH'(1);
            end
        end
        if (wr_c && word_c == A_WLOAD && bus_wdata[WDT_WIDTH-1:0] != '0) begin
            wdt_load_d = bus_wdata[WDT_WIDTH-1:0];
            wdt_cnt_d  = bus_wdata[WDT_WIDTH-1:0];
            wdt_en_d   = 1'b1;
        end

        match_d       = (match_q & ~clr_c[NUM_CH-1:0])  | match_set;
        capf_d        = (capf_q  & ~clr_c[8 +: NUM_CH])  | cap_set;
        ovr_d         = (ovr_q   & ~clr_c[16 +: NUM_CH]) | ovr_set;
        bark_d        = (bark_q  & ~clr_c[31]) | bark_set;
        wdt_rst_req_d = wdt_rst_req | rst_set;
        irq_d         = (|((match_q | capf_q) & irq_en_q)) | bark_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en_q   <= 1'b0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cmp_q[i]  <= '0;
                duty_q[i] <= '0;
                cap_q[i]  <= '0;
                cnt_q[i]  <= '0;
            end
            run_q       <= '0;
            pwm_en_q    <= '0;
            cap_en_q    <= '0;
            cap_edge_q  <= '0;
            one_shot_q  <= '0;
            irq_en_q    <= '0;
            match_q     <= '0;
            capf_q      <= '0;
            ovr_q       <= '0;
            bark_q      <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            wdt_load_q  <= '0;
            wdt_cnt_q   <= '0;
            wdt_en_q    <= 1'b0;
            wdt_rst_req <= 1'b0;
            pwm_out     <= '0;
            irq_timer   <= 1'b0;
        end else begin
            ctrl_en_q   <= ctrl_en_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cmp_q[i]  <= cmp_d[i];
                duty_q[i] <= duty_d[i];
                cap_q[i]  <= cap_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            run_q       <= run_d;
            pwm_en_q    <= pwm_en_d;
            cap_en_q    <= cap_en_d;
            cap_edge_q  <= cap_edge_d;
            one_shot_q  <= one_shot_d;
            irq_en_q    <= irq_en_d;
            match_q     <= match_d;
            capf_q      <= capf_d;
            ovr_q       <= ovr_d;
            bark_q      <= bark_d;
            sync1_q     <= cap_in;
            sync2_q     <= sync1_q;
            sync3_q     <= sync2_q;
            wdt_load_q  <= wdt_load_d;
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_en_q    <= wdt_en_d;
            wdt_rst_req <= wdt_rst_req_d;
            pwm_out     <= pwm_d;
            irq_timer   <= irq_d;
        end
    end

endmodule

// File: tb/tb_qar_timer_array.sv
// Directed bench for qar_timer_array: match/IRQ, capture, PWM, one-shot,
// watchdog and asynchronous reset, each against hand-computed values.
module tb_qar_timer_array;

    localparam int unsigned NUM_CH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              bus_valid, bus_we, bus_ready;
    logic [7:0]        bus_addr;
    logic [31:0]       bus_wdata, bus_rdata;
    logic [NUM_CH-1:0] cap_in, pwm_out;
    logic              irq_timer, wdt_rst_req;

    int n_tests = 0;
    int n_fail  = 0;

    qar_timer_array #(.NUM_CH(NUM_CH), .CNT_WIDTH(32), .PRESC_WIDTH(8), .WDT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .cap_in(cap_in), .pwm_out(pwm_out), .irq_timer(irq_timer), .wdt_rst_req(wdt_rst_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_valid = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
        @(posedge clk);
        #1;
        bus_valid = 1'b0; bus_we = 1'b0;
    endtask

    // Reads sample mid-cycle and never cross a clock edge
    task automatic expect_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
        @(negedge clk);
        bus_valid = 1'b1; bus_we = 1'b0; bus_addr = a;
        #1;
        check(tag, bus_rdata, exp);
        bus_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // High count over the first 40 samples, longest high and low runs over 60
    task automatic pwm_profile(input int ch, output int hi, output int max_hi, output int max_lo);
        int  run_len;
        logic cur, prev;
        hi = 0; max_hi = 0; max_lo = 0; run_len = 0; prev = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step(1);
            cur = pwm_out[ch];
            if (k < 40 && cur) hi++;
            run_len = (k == 0 || cur != prev) ? 1 : run_len + 1;
            if (cur && run_len > max_hi)  max_hi = run_len;
            if (!cur && run_len > max_lo) max_lo = run_len;
            prev = cur;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int hi, max_hi, max_lo;
        rst_n = 1'b0; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0; cap_in = '0;

        // Reset state
        #12;
        check("rst_pwm", 32'(pwm_out), 32'h0);
        check("rst_irq", 32'(irq_timer), 32'h0);
        check("rst_wdt", 32'(wdt_rst_req), 32'h0);
        check("rst_rdata_idle", bus_rdata, 32'h0);
        bus_valid = 1'b1;
        #1;
        check("ready_follows_valid", 32'(bus_ready), 32'h1);
        bus_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_reg("rst_ctrl", 8'h00, 32'h0);
        expect_reg("rst_status", 8'h04, 32'h0);

        // Periodic match on ch0: PRESC=0, CMP=9, run+irq_en
        bus_write(8'h10, 32'd9);
        bus_write(8'h1C, 32'h21);
        bus_write(8'h00, 32'h1);
        step(9);
        expect_reg("match_early", 8'h04, 32'h0);
        check("irq_early", 32'(irq_timer), 32'h0);
        step(1);
        expect_reg("match_set", 8'h04, 32'h1);
        check("irq_latency", 32'(irq_timer), 32'h0);
        step(1);
        check("irq_set", 32'(irq_timer), 32'h1);
        bus_write(8'h04, 32'h1);
        check("irq_hold_w1c_cycle", 32'(irq_timer), 32'h1);
        step(1);
        check("irq_cleared", 32'(irq_timer), 32'h0);
        expect_reg("w1c_status", 8'h04, 32'h0);
        bus_write(8'h1C, 32'h0);
        bus_write(8'h04, 32'hFFFF_FFFF);

        // Capture on ch1, rising edge at cnt=0x61
        bus_write(8'h20, 32'hFFFF);
        bus_write(8'h2C, 32'h05);
        step(97);
        cap_in[1] = 1'b1;
        step(2);
        expect_reg("cap_latency", 8'h28, 32'h0);
        step(1);
        expect_reg("cap_value", 8'h28, 32'h64);
        expect_reg("cap_flag", 8'h04, 32'h200);
        cap_in[1] = 1'b0;
        step(3);
        cap_in[1] = 1'b1;
        step(4);
        expect_reg("cap_overrun", 8'h04, 32'h0002_0200);
        bus_write(8'h2C, 32'h0);
        bus_write(8'h04, 32'hFFFF_FFFF);
        cap_in = '0;

        // PWM on ch2: PRESC=1, CMP=9, DUTY=4 -> 8 high / 12 low
        bus_write(8'h00, 32'h101);
        bus_write(8'h30, 32'd9);
        bus_write(8'h34, 32'd4);
        bus_write(8'h3C, 32'h03);
        step(40);
        pwm_profile(2, hi, max_hi, max_lo);
        check("pwm_high_count", 32'(hi), 32'd16);
        check("pwm_high_run", 32'(max_hi), 32'd8);
        check("pwm_low_run", 32'(max_lo), 32'd12);
        bus_write(8'h34, 32'd0);
        step(3);
        pwm_profile(2, hi, max_hi, max_lo);
        check("pwm_duty0", 32'(hi), 32'd0);
        bus_write(8'h34, 32'd10);
        step(3);
        pwm_profile(2, hi, max_hi, max_lo);
        check("pwm_duty_gt_cmp", 32'(hi), 32'd40);
        bus_write(8'h3C, 32'h0);
        bus_write(8'h00, 32'h1);
        bus_write(8'h04, 32'hFFFF_FFFF);

        // One-shot on ch3, capture enabled to observe the parked counter
        bus_write(8'h40, 32'd5);
        bus_write(8'h4C, 32'h15);
        step(10);
        expect_reg("oneshot_match", 8'h04, 32'h8);
        expect_reg("oneshot_run_clr", 8'h4C, 32'h14);
        bus_write(8'h04, 32'h8);
        step(20);
        expect_reg("oneshot_no_rematch", 8'h04, 32'h0);
        cap_in[3] = 1'b1;
        step(4);
        expect_reg("oneshot_cnt_zero", 8'h48, 32'h0);
        expect_reg("oneshot_cap_flag", 8'h04, 32'h800);
        bus_write(8'h4C, 32'h0);
        bus_write(8'h04, 32'hFFFF_FFFF);
        cap_in = '0;

        // Watchdog without valid kicks: bark at 100, reset request at 200
        bus_write(8'h08, 32'd100);
        expect_reg("wdt_load_rb", 8'h08, 32'd100);
        step(9);
        bus_write(8'h0C, 32'h1234);
        step(89);
        expect_reg("bark_early", 8'h04, 32'h0);
        step(1);
        expect_reg("bark_set", 8'h04, 32'h8000_0000);
        check("wdt_req_early", 32'(wdt_rst_req), 32'h0);
        step(1);
        check("irq_bark", 32'(irq_timer), 32'h1);
        step(98);
        check("wdt_req_before", 32'(wdt_rst_req), 32'h0);
        step(1);
        check("wdt_req_set", 32'(wdt_rst_req), 32'h1);
        step(5);
        check("wdt_req_sticky", 32'(wdt_rst_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("wdt_req_async_clr", 32'(wdt_rst_req), 32'h0);
        check("irq_async_clr", 32'(irq_timer), 32'h0);
        step(2);
        @(negedge clk);
        rst_n = 1'b1;

        // Watchdog kicked every 49 cycles never fires
        bus_write(8'h08, 32'd100);
        for (int k = 0; k < 6; k++) begin
            step(48);
            bus_write(8'h0C, 32'h5A5A);
        end
        step(10);
        expect_reg("kick_no_bark", 8'h04, 32'h0);
        check("kick_no_req", 32'(wdt_rst_req), 32'h0);
        do_reset();

        // Asynchronous reset while counting with IRQ pending
        bus_write(8'h00, 32'h1);
        bus_write(8'h10, 32'd3);
        bus_write(8'h1C, 32'h21);
        bus_write(8'h20, 32'd20);
        bus_write(8'h24, 32'd20);
        bus_write(8'h2C, 32'h07);
        cap_in[1] = 1'b1;
        step(7);
        check("pre_rst_irq", 32'(irq_timer), 32'h1);
        check("pre_rst_pwm", 32'(pwm_out), 32'h2);
        expect_reg("pre_rst_cap", 8'h28, 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pwm", 32'(pwm_out), 32'h0);
        check("mid_rst_irq", 32'(irq_timer), 32'h0);
        check("mid_rst_wdt", 32'(wdt_rst_req), 32'h0);
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        expect_reg("post_rst_cap", 8'h28, 32'h0);
        expect_reg("post_rst_status", 8'h04, 32'h0);
        expect_reg("post_rst_ctrl", 8'h00, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
